// File: rtl/switch_in_pkg.sv
// Shared constants and helpers for the switch input port block.
package switch_in_pkg;

  localparam int NUM_SW = 10;
  localparam int PORT_W = 5;
  localparam int DATA_W = 32;

  typedef enum logic {
    PORT_0 = 1'b0,
    PORT_1 = 1'b1
  } port_e;

  localparam int PORT0_IDX = 0;
  localparam int PORT1_IDX = 1;

  // Selects the five switch levels that belong to one CPU-visible port.
  function automatic logic [PORT_W-1:0] port_field(input logic [NUM_SW-1:0] levels,
                                                   input logic             port);
    return port ? levels[PORT_W +: PORT_W] : levels[0 +: PORT_W];
  endfunction

endpackage

// File: rtl/switch_debounce_bit.sv
// One switch bit: 2-flop synchronizer, optional debounce counter, stable flop.
// Debounce is built only when SWITCH_IN_DEBOUNCE_EN is defined.
module switch_debounce_bit #(
  parameter int DB_CYCLES = 50000
) (
  input  logic clk,
  input  logic reset,
  input  logic sw,
  output logic stable
);

  if (DB_CYCLES < 1) begin : g_bad_cfg
    $error("DB_CYCLES must be at least 1");
  end

  logic sync1;
  logic sync2;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; blocking here would collapse the two synchronizer stages.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= sw;
      sync2 <= sync1;
    end
  end

`ifdef SWITCH_IN_DEBOUNCE_EN
  localparam int CNT_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 1);

  logic [CNT_W-1:0] cnt;

  // Count consecutive disagreeing cycles; any agreement restarts the count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt    <= '0;
      stable <= 1'b0;
    end else if (sync2 == stable) begin
      cnt <= '0;
    end else if (cnt == CNT_MAX) begin
      stable <= sync2;
      cnt    <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end
`else
  assign stable = sync2;
`endif

endmodule

// File: rtl/switch_in_port.sv
// Debounced 10-switch input block exposed to the CPU as two 5-bit read ports
// with sticky change flags. Debounce enabled by defining SWITCH_IN_DEBOUNCE_EN.
module switch_in_port
  import switch_in_pkg::*;
#(
  parameter int DB_CYCLES = 50000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NUM_SW-1:0] sw,
  input  logic              rd_en,
  input  logic              rd_port,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic [1:0]        changed,
  output logic [NUM_SW-1:0] stable
);

  for (genvar i = 0; i < NUM_SW; i++) begin : g_bit
    switch_debounce_bit #(
      .DB_CYCLES(DB_CYCLES)
    ) u_bit (
      .clk   (clk),
      .reset (reset),
      .sw    (sw[i]),
      .stable(stable[i])
    );
  end

  logic [NUM_SW-1:0] stable_q;
  logic [1:0]        set_flag;
  logic [1:0]        clr_flag;
  port_e             sel;

  // NOTE: every signal driven in always_comb gets a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    set_flag = '0;
    clr_flag = '0;
    sel      = port_e'(rd_port);
    set_flag[PORT0_IDX] = |(port_field(stable, PORT_0) ^ port_field(stable_q, PORT_0));
    set_flag[PORT1_IDX] = |(port_field(stable, PORT_1) ^ port_field(stable_q, PORT_1));
    if (rd_en) begin
      clr_flag[sel] = 1'b1;
    end
  end

  // A set in the same cycle as a clear wins, so no change event is dropped.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stable_q <= '0;
      changed  <= '0;
    end else begin
      stable_q <= stable;
      changed  <= set_flag | (changed & ~clr_flag);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) begin
        rd_data <= {{(DATA_W - PORT_W){1'b0}}, port_field(stable, rd_port)};
      end
    end
  end

endmodule

// File: tb/tb_switch_in_port.sv
// Directed bench for switch_in_port with DB_CYCLES=4; expectations follow the
// build (debounced when SWITCH_IN_DEBOUNCE_EN is defined, direct otherwise).
module tb_switch_in_port;

  localparam int DB = 4;
`ifdef SWITCH_IN_DEBOUNCE_EN
  localparam bit DEB = 1'b1;
  localparam int LAT = 2 + DB;
`else
  localparam bit DEB = 1'b0;
  localparam int LAT = 2;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [9:0]  sw = '0;
  logic        rd_en = 1'b0;
  logic        rd_port = 1'b0;
  logic [31:0] rd_data;
  logic        rd_valid;
  logic [1:0]  changed;
  logic [9:0]  stable;

  int errors = 0;
  int checks = 0;

  switch_in_port #(.DB_CYCLES(DB)) dut (
    .clk     (clk),
    .reset   (reset),
    .sw      (sw),
    .rd_en   (rd_en),
    .rd_port (rd_port),
    .rd_data (rd_data),
    .rd_valid(rd_valid),
    .changed (changed),
    .stable  (stable)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled on falling edges.
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset;
    @(negedge clk);
    reset = 1'b1;
    step(2);
    checks++;
    if ({stable, changed, rd_valid, rd_data} !== '0) begin
      errors++;
      $display("FAIL reset_state: stable=%h changed=%b rd_valid=%b rd_data=%h, required all 0",
               stable, changed, rd_valid, rd_data);
    end
    reset = 1'b0;
    step(1);
  endtask

  task automatic test_port0_edge_and_read;
    sw = 10'h001;
    step(LAT - 1);
    checks++;
    if (stable !== 10'h000) begin
      errors++;
      $display("FAIL p0_early: stable=%h, required 000", stable);
    end
    step(1);
    checks++;
    if (stable !== 10'h001 || changed !== 2'b00) begin
      errors++;
      $display("FAIL p0_accept: stable=%h changed=%b, required 001 / 00", stable, changed);
    end
    step(1);
    checks++;
    if (changed !== 2'b01) begin
      errors++;
      $display("FAIL p0_changed: changed=%b, required 01", changed);
    end
    rd_en = 1'b1; rd_port = 1'b0;
    step(1);
    rd_en = 1'b0;
    checks++;
    if (rd_data !== 32'h1 || rd_valid !== 1'b1 || changed !== 2'b00) begin
      errors++;
      $display("FAIL p0_read: rd_data=%h rd_valid=%b changed=%b, required 00000001 / 1 / 00",
               rd_data, rd_valid, changed);
    end
    step(1);
    checks++;
    if (rd_valid !== 1'b0 || rd_data !== 32'h1) begin
      errors++;
      $display("FAIL p0_hold: rd_valid=%b rd_data=%h, required 0 / 00000001", rd_valid, rd_data);
    end
  endtask

  task automatic test_glitch_and_hold;
    logic [1:0] exp_chg;
    sw = 10'h081;
    step(3);
    sw = 10'h001;
    step(LAT + 3);
    exp_chg = DEB ? 2'b00 : 2'b10;
    checks++;
    if (stable !== 10'h001 || changed !== exp_chg) begin
      errors++;
      $display("FAIL glitch: stable=%h changed=%b, required 001 / %b", stable, changed, exp_chg);
    end
    rd_en = 1'b1; rd_port = 1'b1;
    step(1);
    rd_en = 1'b0;
    sw = 10'h081;
    step(LAT);
    checks++;
    if (stable !== 10'h081) begin
      errors++;
      $display("FAIL hold_accept: stable=%h, required 081", stable);
    end
    step(1);
    checks++;
    if (changed !== 2'b10) begin
      errors++;
      $display("FAIL hold_changed: changed=%b, required 10", changed);
    end
    rd_en = 1'b1; rd_port = 1'b1;
    step(1);
    rd_en = 1'b0;
    checks++;
    if (rd_data !== 32'h04 || changed !== 2'b00) begin
      errors++;
      $display("FAIL p1_read: rd_data=%h changed=%b, required 00000004 / 00", rd_data, changed);
    end
  endtask

  task automatic test_set_wins;
    sw = 10'h281;
    step(LAT);
    rd_en = 1'b1; rd_port = 1'b1;
    step(1);
    rd_en = 1'b0;
    checks++;
    if (changed !== 2'b10 || rd_data !== 32'h14) begin
      errors++;
      $display("FAIL set_wins: changed=%b rd_data=%h, required 10 / 00000014", changed, rd_data);
    end
    rd_en = 1'b1;
    step(1);
    rd_en = 1'b0;
    checks++;
    if (changed !== 2'b00) begin
      errors++;
      $display("FAIL set_wins_clear: changed=%b, required 00", changed);
    end
  endtask

  task automatic test_reset_mid_count;
    sw = 10'h3FF;
    step(4);
    reset = 1'b1;
    #1;
    checks++;
    if (stable !== 10'h000 || changed !== 2'b00 || rd_data !== 32'h0) begin
      errors++;
      $display("FAIL mid_reset: stable=%h changed=%b rd_data=%h, required 000 / 00 / 0",
               stable, changed, rd_data);
    end
    step(1);
    reset = 1'b0;
    step(LAT - 1);
    checks++;
    if (stable !== 10'h000) begin
      errors++;
      $display("FAIL post_reset_early: stable=%h, required 000", stable);
    end
    step(1);
    checks++;
    if (stable !== 10'h3FF) begin
      errors++;
      $display("FAIL post_reset_accept: stable=%h, required 3ff", stable);
    end
    step(1);
    checks++;
    if (changed !== 2'b11) begin
      errors++;
      $display("FAIL post_reset_changed: changed=%b, required 11", changed);
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] exp_data [3];
    logic        ports    [3];
    exp_data = '{32'h05, 32'h15, 32'h05};
    ports    = '{1'b0, 1'b1, 1'b0};
    sw = 10'h2A5;
    step(LAT + 2);
    for (int i = 0; i < 3; i++) begin
      rd_en = 1'b1; rd_port = ports[i];
      step(1);
      checks++;
      if (rd_data !== exp_data[i] || rd_valid !== 1'b1) begin
        errors++;
        $display("FAIL b2b_%0d: rd_data=%h rd_valid=%b, required %h / 1",
                 i, rd_data, rd_valid, exp_data[i]);
      end
    end
    rd_en = 1'b0;
    step(1);
    checks++;
    if (rd_valid !== 1'b0 || rd_data !== 32'h05 || changed !== 2'b00) begin
      errors++;
      $display("FAIL b2b_end: rd_valid=%b rd_data=%h changed=%b, required 0 / 00000005 / 00",
               rd_valid, rd_data, changed);
    end
  endtask

  initial begin
    test_reset();
    test_port0_edge_and_read();
    test_glitch_and_hold();
    test_set_wins();
    test_reset_mid_count();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
